sar_busca4bit: RTL
==================

Name: sar_busca4bit

Overview:
Successive-approximation search controller that drives the trial operand of an external magnitude comparator and converges on the unknown operand.
- Comparator port a carries the unknown value; port b is driven from tentativa.
- The block reads back maior/menor/igual and resolves the unknown value MSB-first.
- Terminates early on igual and reports inconsistent comparator answers.
- Used for value discovery and as a closed-loop exerciser for the team's comparators.

Parameters:
WIDTH, 4, operand width in bits (>=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new search; accepted only in OCIOSO
tentativa  out  WIDTH  registered trial value, wired to comparator input b
maior  in  1  comparator: a > tentativa (combinational, settles within the cycle)
menor  in  1  comparator: a < tentativa
igual  in  1  comparator: a == tentativa
resultado  out  WIDTH  found value; held from FIM until the next accepted start
ocupado  out  1  high while in TESTA
pronto  out  1  one-cycle pulse in FIM
erro  out  1  set with resultado in FIM, held until the next accepted start

Behaviour:
- Reset: one clock, synchronous active-high reset. All registers are reset on a clk edge with rst=1: state=OCIOSO, tentativa=0, resultado=0, idx=0, ocupado=0, pronto=0, erro=0.
- Reset priority: rst overrides start and any in-flight search, which is abandoned without a pronto pulse.
- Internal state: idx is a bit index, clog2(WIDTH) bits wide.
- FSM states: OCIOSO, TESTA, FIM.
- OCIOSO:
  - tentativa=0.
  - On start=1: tentativa <= 1<<(WIDTH-1), idx <= WIDTH-1, erro <= 0, then go to TESTA.
- TESTA: flags are sampled at each edge. "Valid" means exactly one of maior/menor/igual is high.
  - Invalid flags (none or several high): resultado <= tentativa, erro <= 1, go to FIM.
  - igual: resultado <= tentativa, go to FIM.
  - menor, idx>0: clear bit idx, set bit idx-1, idx--.
  - maior, idx>0: keep bit idx, set bit idx-1, idx--.
  - menor, idx==0: resultado <= tentativa with bit0 cleared, go to FIM.
  - maior, idx==0: contradicts earlier decisions. resultado <= tentativa, erro <= 1, go to FIM.
- FIM:
  - pronto=1 for exactly one cycle; ocupado=0; tentativa holds its last value.
  - Then go to OCIOSO unconditionally.
- start handling: start in TESTA or FIM is ignored and not queued. start held high re-triggers only once OCIOSO is reached.
- Outputs: ocupado and pronto are decoded from registered state and are glitch-free.
- Latency: start sampled at edge k puts tentativa=MSB-only in cycle k+1.
  - pronto is high in cycle k+1+n, where n = number of TESTA cycles (1..WIDTH).
  - Worst case is WIDTH+1 cycles from start to pronto.
- Width rules:
  - tentativa and resultado are WIDTH bits and unsigned; no wrap is possible.
  - idx never underflows, because idx==0 always exits to FIM.
- resultado and erro are not changed by a search that reset aborts before FIM.

Decomposition:
- Shared package sar_pkg:
  - state enum (OCIOSO=2'd0, TESTA=2'd1, FIM=2'd2).
  - DEF_WIDTH=4.
  - function onehot3(maior, menor, igual).
- Sub-modules: none. The comparator stays external.
- Bench: pairs the block with an ideal behavioural comparator for a = unknown value. Fault injection forces the flags directly.

Test Plan:
- a=0xB, start pulse: tentativa sequence 8,C,A,B (flags maior, menor, maior, igual) -> pronto in cycle k+5, resultado=0xB, erro=0, ocupado high for 4 cycles.
- a=0x8: first trial gives igual -> pronto in cycle k+2, resultado=0x8, ocupado high for 1 cycle.
- a=0x0: trials 8,4,2,1, all menor -> resultado=0x0, pronto in cycle k+5, erro=0. a=0xF: trials 8,C,E,F -> resultado=0xF.
- Fault injection:
  - Force flags=000 in the first TESTA cycle -> FIM next, resultado=0x8, erro=1.
  - Force maior at idx==0 -> erro=1.
  - erro clears on the next accepted start.
- Busy handling: start held high during the whole search -> no restart mid-search. pronto pulses once, then a new search begins in the cycle after OCIOSO accepts.
- Mid-search reset: rst=1 for one cycle during the 3rd TESTA cycle -> next cycle all outputs are 0 with state OCIOSO. No pronto pulse. A subsequent start searches correctly.

Source files
------------

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and helpers for the successive-approximation search controller
//
// Contents:
//   DEF_WIDTH : default operand width
//   state_t   : controller states (OCIOSO idle, TESTA testing, FIM done)
//   onehot3   : true when exactly one comparator flag is asserted

package sar_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    TESTA  = 2'd1,
    FIM    = 2'd2
  } state_t;

  // A well-behaved comparator asserts exactly one of its three outputs.
  function automatic logic onehot3(input logic maior, input logic menor, input logic igual);
    return (maior ^ menor ^ igual) & ~(maior & menor & igual);
  endfunction

endpackage

// File: rtl/sar_busca4bit.sv
// rtl/sar_busca4bit.sv - MSB-first successive-approximation search driving an external comparator
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : request a new search (accepted only while idle)
//   tentativa  : registered trial value, drives comparator input b
//   maior      : comparator says unknown > tentativa
//   menor      : comparator says unknown < tentativa
//   igual      : comparator says unknown == tentativa
//   resultado  : value found, held until the next accepted start
//   ocupado    : high while trials are in progress
//   pronto     : one-cycle pulse when the search finishes
//   erro       : comparator answers were inconsistent, held with resultado

module sar_busca4bit
  import sar_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] tentativa,
  input  logic             maior,
  input  logic             menor,
  input  logic             igual,
  output logic [WIDTH-1:0] resultado,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [IDX_W-1:0] idx;

  // mask_cur selects the bit currently under test, mask_nxt the one below it.
  logic [WIDTH-1:0] mask_cur;
  logic [WIDTH-1:0] mask_nxt;
  logic             flags_ok;
  logic             last_bit;

  assign mask_cur = WIDTH'(1) << idx;
  assign mask_nxt = mask_cur >> 1;
  assign flags_ok = onehot3(maior, menor, igual);
  assign last_bit = (idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OCIOSO;
      tentativa <= '0;
      resultado <= '0;
      idx       <= '0;
      erro      <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          if (start) begin
            tentativa <= MSB_ONLY;
            idx       <= IDX_W'(WIDTH - 1);
            erro      <= 1'b0;
            state     <= TESTA;
          end else begin
            tentativa <= '0;
          end
        end

        TESTA: begin
          if (!flags_ok) begin
            resultado <= tentativa;
            erro      <= 1'b1;
            state     <= FIM;
          end else if (igual) begin
            resultado <= tentativa;
            state     <= FIM;
          end else if (menor) begin
            if (last_bit) begin
              // Unknown is below a value whose LSB is set: it is that value minus one.
              resultado <= tentativa & ~mask_cur;
              state     <= FIM;
            end else begin
              tentativa <= (tentativa & ~mask_cur) | mask_nxt;
              idx       <= idx - 1'b1;
            end
          end else begin
            // maior at the LSB cannot happen with a consistent comparator:
            // every earlier decision bounded the unknown to tentativa or tentativa-1.
            if (last_bit) begin
              resultado <= tentativa;
              erro      <= 1'b1;
              state     <= FIM;
            end else begin
              tentativa <= tentativa | mask_nxt;
              idx       <= idx - 1'b1;
            end
          end
        end

        FIM: begin
          // tentativa keeps the last trial during FIM and returns to zero in OCIOSO.
          tentativa <= '0;
          state     <= OCIOSO;
        end

        default: begin
          tentativa <= '0;
          state     <= OCIOSO;
        end
      endcase
    end
  end

  // Decoded directly from the state register, so both are glitch-free.
  assign ocupado = (state == TESTA);
  assign pronto  = (state == FIM);

endmodule
